// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte/half/word load/store requests into single-cycle
// RAM accesses with lane enables, and returns aligned, extended load data or an error.
module dmem_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RSP     = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]    state;
    logic [1:0]    ld_off;
    logic [1:0]    ld_size;
    logic          ld_uns;

    logic          accept;
    logic          req_err;
    logic [MW-1:0] lane_mask;
    logic [DW-1:0] lane_data;
    logic [DW-1:0] ld_shift;
    logic [DW-1:0] ld_ext;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        lane_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                lane_mask = MW'(1) << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = MW'(3) << req_addr[1:0];
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_mask = '1;
                lane_data = req_wdata;
            end
        endcase
    end

    // RAM port is driven straight from the request so the access happens in the accept cycle.
    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign ram_cs    = accept & ~req_err;
    assign ram_we    = ram_cs & req_we;
    assign ram_wem   = ram_we ? lane_mask : '0;
    assign ram_addr  = ram_cs ? req_addr : '0;
    assign ram_din   = ram_cs ? lane_data : '0;
    assign rsp_valid = (state == RSP);

    assign ld_shift = ram_dout >> {ld_off, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (ld_size)
            SZ_BYTE: ld_ext = ld_uns ? {{(DW-8){1'b0}}, ld_shift[7:0]}
                                     : {{(DW-8){ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_ext = ld_uns ? {{(DW-16){1'b0}}, ld_shift[15:0]}
                                     : {{(DW-16){ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ld_off    <= '0;
            ld_size   <= '0;
            ld_uns    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= RSP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state     <= RSP;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state   <= RD_WAIT;
                            ld_off  <= req_addr[1:0];
                            ld_size <= req_size;
                            ld_uns  <= req_unsigned;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_rdata <= ld_ext;
                    rsp_err   <= 1'b0;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
